// File: rtl/rr_pack_pkg.sv
// Shared constants, frame type and width helpers for the logging-bus frame packer.
package rr_pack_pkg;

    localparam int ALIGN_DEF = 32;
    localparam int STAT_W    = 32;

    typedef logic [ALIGN_DEF-1:0] rr_frame_t;

    function automatic int nf_width(input int max_frames);
        return $clog2(max_frames + 1);
    endfunction

    function automatic int total_width(input int nch, input int max_frames);
        return $clog2(nch * max_frames + 1);
    endfunction

endpackage

// File: rtl/rr_logb_frame_packer_if.sv
// Group-in / packed-word-out handshake bundle for rr_logb_frame_packer.
interface rr_logb_frame_packer_if
    import rr_pack_pkg::*;
#(
    parameter int NCH        = 4,
    parameter int ALIGN      = ALIGN_DEF,
    parameter int MAX_FRAMES = 4
) ();
    localparam int FW = nf_width(MAX_FRAMES);
    localparam int OW = total_width(NCH, MAX_FRAMES);

    logic [NCH-1:0]                       in_valid;
    logic [NCH-1:0][MAX_FRAMES*ALIGN-1:0] in_data;
    logic [NCH-1:0][FW-1:0]               in_nframes;
    logic                                 in_ready;
    logic                                 out_valid;
    logic [NCH*MAX_FRAMES*ALIGN-1:0]      out_data;
    logic [OW-1:0]                        out_nframes;
    logic                                 out_ready;

    modport master (
        output in_valid, in_data, in_nframes, out_ready,
        input  in_ready, out_valid, out_data, out_nframes
    );

    modport slave (
        input  in_valid, in_data, in_nframes, out_ready,
        output in_ready, out_valid, out_data, out_nframes
    );

endinterface

// File: rtl/rr_pack_prefix_offsets.sv
// Combinational exclusive prefix sum of per-channel frame counts, plus the group total.
module rr_pack_prefix_offsets
    import rr_pack_pkg::*;
#(
    parameter int NCH = 4,
    parameter int FW  = nf_width(4),
    parameter int OW  = total_width(4, 4)
) (
    input  logic [NCH-1:0][FW-1:0] nf,
    output logic [NCH-1:0][OW-1:0] off,
    output logic [OW-1:0]          total
);
    logic [OW-1:0] acc;

    always_comb begin
        acc = '0;
        off = '0;
        for (int c = 0; c < NCH; c++) begin
            off[c] = acc;
            acc    = acc + OW'(nf[c]);
        end
        total = acc;
    end

endmodule

// File: rtl/rr_logb_frame_packer.sv
// Two-stage N-channel frame packer with lossless valid/ready stall.
// Optional stat counters are built only when RR_PACK_STATS_EN is defined.
module rr_logb_frame_packer
    import rr_pack_pkg::*;
#(
    parameter int NCH        = 4,
    parameter int ALIGN      = ALIGN_DEF,
    parameter int MAX_FRAMES = 4,
    parameter bit SAT_MSG_EN = 1'b1
) (
    input  logic                clk,
    input  logic                rstn,
    rr_logb_frame_packer_if.slave bus,
    output logic [STAT_W-1:0]   stat_groups,
    output logic [STAT_W-1:0]   stat_frames,
    output logic [STAT_W-1:0]   stat_stalls
);
    localparam int FW = nf_width(MAX_FRAMES);
    localparam int OW = total_width(NCH, MAX_FRAMES);
    localparam int PW = MAX_FRAMES * ALIGN;
    localparam int DW = NCH * PW;

    logic                   in_hs;
    logic [NCH-1:0][FW-1:0] nf_eff;
    logic [NCH-1:0][OW-1:0] off_in;
    logic [OW-1:0]          total_in;

    logic                   s1_valid, s1_ready;
    logic [NCH-1:0][PW-1:0] s1_data;
    logic [NCH-1:0][FW-1:0] s1_nf;
    logic [NCH-1:0][OW-1:0] s1_off;
    logic [OW-1:0]          s1_total;
    logic [DW-1:0]          pack_word;

    logic                   s2_valid, s2_ready;
    logic [DW-1:0]          s2_data;
    logic [OW-1:0]          s2_nframes;

    assign s2_ready     = !s2_valid || bus.out_ready;
    assign s1_ready     = !s1_valid || s2_ready;
    assign bus.in_ready = s1_ready;
    assign in_hs        = (|bus.in_valid) && s1_ready;

    // Idle channels contribute nothing; oversize counts clamp to MAX_FRAMES.
    always_comb begin
        nf_eff = '0;
        for (int c = 0; c < NCH; c++)
            if (bus.in_valid[c])
                nf_eff[c] = (bus.in_nframes[c] > FW'(MAX_FRAMES)) ? FW'(MAX_FRAMES)
                                                                   : bus.in_nframes[c];
    end

    rr_pack_prefix_offsets #(.NCH(NCH), .FW(FW), .OW(OW)) u_prefix (
        .nf    (nf_eff),
        .off   (off_in),
        .total (total_in)
    );

    // Zero-length groups complete the handshake but never occupy S1.
    always_ff @(posedge clk) begin
        if (!rstn)
            s1_valid <= 1'b0;
        else if (s1_ready)
            s1_valid <= in_hs && (total_in != '0);
    end

    always_ff @(posedge clk) begin
        if (in_hs) begin
            s1_data  <= bus.in_data;
            s1_nf    <= nf_eff;
            s1_off   <= off_in;
            s1_total <= total_in;
        end
    end

    always_comb begin
        pack_word = '0;
        for (int c = 0; c < NCH; c++)
            for (int j = 0; j < MAX_FRAMES; j++)
                if (FW'(j) < s1_nf[c])
                    pack_word[(int'(s1_off[c]) + j)*ALIGN +: ALIGN] = s1_data[c][j*ALIGN +: ALIGN];
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            s2_valid   <= 1'b0;
            s2_data    <= '0;
            s2_nframes <= '0;
        end else if (s2_ready) begin
            s2_valid   <= s1_valid;
            s2_data    <= s1_valid ? pack_word : '0;
            s2_nframes <= s1_valid ? s1_total  : '0;
        end
    end

    assign bus.out_valid   = s2_valid;
    assign bus.out_data    = s2_data;
    assign bus.out_nframes = s2_nframes;

`ifdef RR_PACK_STATS_EN
    always_ff @(posedge clk) begin
        if (!rstn) begin
            stat_groups <= '0;
            stat_frames <= '0;
            stat_stalls <= '0;
        end else begin
            if (in_hs)
                stat_groups <= stat_groups + 1'b1;
            if (s2_valid && bus.out_ready)
                stat_frames <= stat_frames + STAT_W'(s2_nframes);
            if (s2_valid && !bus.out_ready)
                stat_stalls <= stat_stalls + 1'b1;
        end
    end
`else
    assign stat_groups = '0;
    assign stat_frames = '0;
    assign stat_stalls = '0;
`endif

    always_ff @(posedge clk) begin
        if (SAT_MSG_EN && rstn && in_hs)
            for (int c = 0; c < NCH; c++)
                if (bus.in_valid[c] && (bus.in_nframes[c] > FW'(MAX_FRAMES)))
                    $error("rr_logb_frame_packer: ch%0d nframes %0d saturated to %0d",
                           c, bus.in_nframes[c], MAX_FRAMES);
    end

endmodule

// File: tb/tb_rr_logb_frame_packer.sv
// Self-checking bench for rr_logb_frame_packer: vector table, scoreboard, stall/reset sequences.
module tb_rr_logb_frame_packer;
    import rr_pack_pkg::*;

    localparam int NCH  = 4;
    localparam int ALIGN = 32;
    localparam int MAXF = 4;
    localparam int FW   = nf_width(MAXF);
    localparam int OW   = total_width(NCH, MAXF);
    localparam int DW   = NCH * MAXF * ALIGN;

`ifdef RR_PACK_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct { logic [DW-1:0] d; logic [OW-1:0] n; } exp_t;
    typedef struct { logic [NCH-1:0] v; logic [NCH-1:0][FW-1:0] nf; int exp_n; } vec_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] st_g, st_f, st_s;
    int          n_chk = 0, n_fail = 0, popped = 0, tag = 0, wait_cyc = 0;
    int          acc_groups = 0, exp_frames = 0;
    exp_t        sb[$];

    rr_logb_frame_packer_if #(.NCH(NCH), .ALIGN(ALIGN), .MAX_FRAMES(MAXF)) bus ();

    // The saturation message is silenced so the saturation vector can run without $error.
    rr_logb_frame_packer #(.NCH(NCH), .ALIGN(ALIGN), .MAX_FRAMES(MAXF), .SAT_MSG_EN(1'b0)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .bus         (bus),
        .stat_groups (st_g),
        .stat_frames (st_f),
        .stat_stalls (st_s)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] sx(input logic [31:0] v);
        return STATS ? v : 32'd0;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [NCH-1:0] v, input logic [NCH-1:0][FW-1:0] nf,
                                   input logic [NCH-1:0][MAXF*ALIGN-1:0] d);
        exp_t e;
        int   k, n;
        e.d = '0;
        k = 0;
        for (int c = 0; c < NCH; c++) begin
            if (v[c]) begin
                n = (int'(nf[c]) > MAXF) ? MAXF : int'(nf[c]);
                for (int j = 0; j < n; j++) begin
                    e.d[k*ALIGN +: ALIGN] = d[c][j*ALIGN +: ALIGN];
                    k++;
                end
            end
        end
        e.n = OW'(k);
        return e;
    endfunction

    // Called right after a posedge (+#1); returns at the same phase once accepted.
    task automatic drive(input logic [NCH-1:0] v, input logic [NCH-1:0][FW-1:0] nf);
        logic [NCH-1:0][MAXF*ALIGN-1:0] d;
        rr_frame_t fr;
        exp_t      e;
        bit        ok;
        ok = 1'b0;
        tag++;
        for (int c = 0; c < NCH; c++)
            for (int j = 0; j < MAXF; j++) begin
                fr = {tag[15:0], 8'(c), 8'(j)};
                d[c][j*ALIGN +: ALIGN] = fr;
            end
        bus.in_valid   = v;
        bus.in_nframes = nf;
        bus.in_data    = d;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
            wait_cyc++;
        end
        if (!ok) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready=0 want 1");
        end else begin
            e = model(v, nf, d);
            if (e.n != '0) sb.push_back(e);
            acc_groups++;
        end
        @(posedge clk);
        #1;
        bus.in_valid = '0;
    endtask

    task automatic wait_pop(input int target, input string name);
        int t;
        t = 0;
        while (popped < target && t < 200) begin
            @(posedge clk);
            t++;
        end
        #1;
        n_chk++;
        if (popped < target) begin
            n_fail++;
            $display("FAIL %s: popped %0d want %0d", name, popped, target);
        end
    endtask

    task automatic wait_valid(input string name, input int exp_n);
        int lat;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.out_valid && lat < 20);
        chk({name, "_latency"}, lat, 2);
        chk({name, "_nframes"}, bus.out_nframes, exp_n);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard pop and stall-stability monitor.
    logic [DW-1:0] prev_d;
    logic [OW-1:0] prev_n;
    logic          prev_stall = 1'b0;
    exp_t          me;
    always @(negedge clk) begin
        if (rstn && prev_stall) begin
            chk("stall_hold_data", bus.out_data, prev_d);
            chk("stall_hold_nframes", bus.out_nframes, prev_n);
        end
        prev_stall = rstn && bus.out_valid && !bus.out_ready;
        prev_d     = bus.out_data;
        prev_n     = bus.out_nframes;
        if (rstn && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_output: got nframes %0d want no output", bus.out_nframes);
            end else begin
                me = sb.pop_front();
                chk("sb_out_data", bus.out_data, me.d);
                chk("sb_out_nframes", bus.out_nframes, me.n);
                exp_frames += int'(me.n);
            end
            popped++;
        end
    end

    initial begin
        vec_t                   vt[5];
        logic [NCH-1:0][FW-1:0] rnf;
        logic [31:0]            s0;
        int                     p0;

        vt[0] = '{4'b1111, {3'd4, 3'd3, 3'd2, 3'd1}, 10};
        vt[1] = '{4'b1010, {3'd1, 3'd0, 3'd2, 3'd0}, 3};
        vt[2] = '{4'b0001, {3'd0, 3'd0, 3'd0, 3'd4}, 4};
        vt[3] = '{4'b0110, {3'd0, 3'd1, 3'd3, 3'd0}, 4};
        vt[4] = '{4'b1001, {3'd2, 3'd4, 3'd4, 3'd3}, 5};

        bus.in_valid   = '0;
        bus.in_data    = '0;
        bus.in_nframes = '0;
        bus.out_ready  = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_nframes", bus.out_nframes, 0);
        chk("rst_stat_groups", st_g, 0);
        chk("rst_stat_frames", st_f, 0);
        chk("rst_stat_stalls", st_s, 0);
        rstn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rel_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 5; i++) begin
            drive(vt[i].v, vt[i].nf);
            wait_valid("table", vt[i].exp_n);
        end
        chk("table_stat_groups", st_g, sx(32'(acc_groups)));
        chk("table_stat_frames", st_f, sx(32'(exp_frames)));

        // Zero-length group is accepted, counted, never emitted.
        s0 = st_g;
        p0 = popped;
        drive(4'b0001, {3'd0, 3'd0, 3'd0, 3'd0});
        drive(4'b0011, {3'd0, 3'd0, 3'd2, 3'd1});
        wait_pop(p0 + 1, "zero_len_pop");
        repeat (4) @(posedge clk);
        #1;
        chk("zero_len_emitted", popped - p0, 1);
        chk("zero_len_stat_groups", st_g - s0, sx(32'd2));

        drive(4'b0100, {3'd0, 3'd7, 3'd0, 3'd0});
        wait_valid("saturate", 4);

        // Back-to-back without backpressure must never wait.
        wait_cyc = 0;
        p0 = popped;
        for (int i = 0; i < 4; i++) drive(4'b1111, {3'd1, 3'd1, 3'd1, 3'd1});
        chk("no_bubble_wait", wait_cyc, 0);
        wait_pop(p0 + 4, "no_bubble_pop");

        // Backpressure: 10 groups, out_ready low for 5 cycles mid-stream.
        p0 = popped;
        s0 = st_s;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    for (int c = 0; c < NCH; c++) rnf[c] = FW'($urandom_range(1, MAXF));
                    drive(4'b1111, rnf);
                end
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                bus.out_ready = 1'b0;
                repeat (2) @(posedge clk);
                @(negedge clk);
                chk("bp_in_ready_low", bus.in_ready, 0);
                chk("bp_out_valid", bus.out_valid, 1);
                repeat (3) @(posedge clk);
                #1;
                bus.out_ready = 1'b1;
            end
        join
        wait_pop(p0 + 10, "bp_delivered");
        chk("bp_stat_stalls", st_s - s0, sx(32'd5));
        chk("bp_sb_empty", sb.size(), 0);

        // Reset with both stages full.
        bus.out_ready = 1'b0;
        drive(4'b1111, {3'd1, 3'd1, 3'd1, 3'd1});
        drive(4'b0011, {3'd0, 3'd0, 3'd2, 3'd2});
        @(negedge clk);
        chk("full_in_ready", bus.in_ready, 0);
        @(posedge clk);
        #1;
        rstn = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_out_valid", bus.out_valid, 0);
        chk("mid_rst_out_nframes", bus.out_nframes, 0);
        chk("mid_rst_out_data", bus.out_data, 0);
        chk("mid_rst_stat_groups", st_g, 0);
        chk("mid_rst_stat_frames", st_f, 0);
        chk("mid_rst_stat_stalls", st_s, 0);
        sb.delete();
        rstn = 1'b1;
        bus.out_ready = 1'b1;
        p0 = popped;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_in_ready", bus.in_ready, 1);
        repeat (5) @(posedge clk);
        #1;
        chk("mid_rst_no_emit", popped - p0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
